spi_mailbox_responder: RTL
==========================

Name: spi_mailbox_responder

Overview:
- SPI mode-0 responder (slave) for the FT2232 SPI master. The FT2232 drives SCK, MOSI and CS; this block answers on MISO.
- Provides a byte mailbox between the terminal host and the 6809 side of the adapter:
  - an RX FIFO, filled by the FT2232 and drained by the 6809 bus logic;
  - a TX FIFO, filled by the 6809 bus logic and drained by the FT2232.
- Runs on clk_100mhz. All SPI inputs are oversampled and synchronized; no logic is clocked by SCK.

Parameters:
- FIFO_DEPTH, 8: entries per FIFO; power of 2, 2..64.
- SYNC_STAGES, 2: synchronizer flops on i_FT_SCK, i_FT_MOSI and i_FT_CS; minimum 2.

Ports:
- clk  in  1  system clock (100 MHz); SCK must be ≤ clk/8.
- reset  in  1  synchronous, active-low reset.
- i_FT_SCK  in  1  SPI clock from FT2232.
- i_FT_MOSI  in  1  SPI data from FT2232.
- i_FT_CS  in  1  chip select, active low.
- o_FT_MISO  out  1  SPI data to FT2232.
- i_rx_pop  in  1  host pops the RX FIFO head.
- o_rx_data  out  8  RX FIFO head, first-word-fall-through.
- o_rx_empty  out  1  RX FIFO empty.
- i_tx_push  in  1  host pushes i_tx_data into the TX FIFO.
- i_tx_data  in  8  TX push data.
- o_tx_full  out  1  TX FIFO full.
- i_clr_flags  in  1  clears the sticky overrun and underrun flags.
- o_irq  out  1  high while the RX FIFO is not empty.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state IDLE; both FIFOs empty.
  - o_FT_MISO=0, o_rx_empty=1, o_tx_full=0, o_irq=0, o_rx_data=0x00.
  - flags cleared; bit counter cleared.
  - Reset taken mid-transfer aborts the transfer immediately.
- Edge detection: on the synchronized signals.
  - SCK rise: shift MOSI in, MSB first.
  - SCK fall: update MISO.
  - CS high at any time: state IDLE, bit counter=0, partial byte discarded, MISO=0.
- Byte boundary: the 8th SCK rise since CS fell or since the last boundary.
- States:
  - IDLE: on CS fall → CMD.
  - CMD: first byte is the command.
    - 0x02 → WRITE
    - 0x03 → READ
    - 0x05 → STATUS
    - any other value → IGNORE
    - MISO stays 0 throughout the command byte.
  - WRITE: each complete byte is pushed to the RX FIFO. If the RX FIFO is full, the byte is dropped and overrun is set. MISO=0.
  - READ: at each boundary (including the command boundary), pop the TX FIFO into the shift register. If the TX FIFO is empty, load 0xFF and set underrun.
  - STATUS: at each boundary, load the status byte: {rx_full, rx_empty, tx_full, tx_empty, overrun, underrun, 2'b00}. It is repeated while CS stays low.
  - IGNORE: MISO=0 until CS rises.
- MISO timing:
  - The shift register is loaded at the boundary.
  - The next SCK fall presents bit 7; each later fall shifts left.
  - The MSB is therefore valid before the first rise of the response byte.
- Latency: CS fall to CMD ≤ SYNC_STAGES+1 clk; MOSI byte complete to RX FIFO entry 1 clk.
- FIFO rules:
  - Simultaneous push and pop on the same FIFO in one clk: both take effect, count unchanged.
  - Host pop when empty: ignored, o_rx_data held.
  - Host push when full: ignored, no flag.
  - Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- Flags: overrun and underrun are sticky. i_clr_flags clears them.
  - If i_clr_flags and a new set event occur in the same clk, set wins.

Optional Feature:
- SPI_MBOX_ECHO_EN defined: adds command 0x0B (ECHO). Each byte received on MOSI is returned on MISO during the following byte; the first response byte is 0x00. FIFOs and flags are untouched.
- SPI_MBOX_ECHO_EN undefined: 0x0B is treated as unknown and goes to IGNORE.

Test Plan:
- CS low, send 0x02,0x41,0x42, CS high → RX FIFO holds 0x41,0x42; o_irq=1; o_rx_data=0x41; after one pop o_rx_data=0x42.
- Host pushes 0x5A,0xC3; FT sends 0x03 then 3 dummy bytes → MISO returns 0x5A,0xC3,0xFF; underrun=1; STATUS then returns 0x54 (rx_empty, tx_empty, underrun set).
- FIFO_DEPTH=8: WRITE with 9 data bytes → 8 stored in order; 9th dropped; overrun=1; i_clr_flags → overrun=0.
- CS raised after 5 bits of the 2nd WRITE data byte → only the 1st byte is stored; next transaction decodes its command correctly.
- reset=0 asserted mid-READ → MISO=0, FIFOs empty, state IDLE at the next clk; host push is accepted normally afterwards.
- With SPI_MBOX_ECHO_EN: send 0x0B,0x11,0x22,0x33 → MISO 0x00,0x00,0x11,0x22. Without the macro: MISO all 0x00.

Source files
------------

// File: rtl/spi_mailbox_responder.sv
// SPI mode-0 responder with RX/TX byte mailboxes, oversampled on clk.
// Define SPI_MBOX_ECHO_EN to add the 0x0B echo command.
module spi_mailbox_responder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_FT_SCK,
  input  logic       i_FT_MOSI,
  input  logic       i_FT_CS,
  output logic       o_FT_MISO,
  input  logic       i_rx_pop,
  output logic [7:0] o_rx_data,
  output logic       o_rx_empty,
  input  logic       i_tx_push,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_full,
  input  logic       i_clr_flags,
  output logic       o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, CMD, WRITE, READ, STATUS, IGNORE, ECHO
  } state_t;

  state_t state, state_d, mode;

  logic [SYNC_STAGES-1:0] sck_sy, mosi_sy, cs_sy;
  logic sck_s, mosi_s, cs_s, sck_q, cs_q;
  logic rise, fall, cs_fall, boundary;

  logic [2:0] bit_cnt;
  logic [7:0] shin, sr, byte_in, load_val, status;
  logic       fresh, miso, ovr, unr;
  logic       load, rx_push, tx_pop, ov_set, un_set;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_pop, tx_push;

  // Synchronizers follow the pins even in reset so no false edge
  // is seen when reset is released with CS already low.
  always_ff @(posedge clk) begin
    sck_sy  <= {sck_sy[SYNC_STAGES-2:0], i_FT_SCK};
    mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], i_FT_MOSI};
    cs_sy   <= {cs_sy[SYNC_STAGES-2:0], i_FT_CS};
    sck_q   <= sck_s;
    cs_q    <= cs_s;
  end

  assign sck_s    = sck_sy[SYNC_STAGES-1];
  assign mosi_s   = mosi_sy[SYNC_STAGES-1];
  assign cs_s     = cs_sy[SYNC_STAGES-1];
  assign rise     = sck_s & ~sck_q;
  assign fall     = ~sck_s & sck_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign boundary = rise && !cs_s && state != IDLE && bit_cnt == 3'd7;
  assign byte_in  = {shin[6:0], mosi_s};

  assign rx_full  = rx_cnt == CW'(FIFO_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign rx_pop   = i_rx_pop && !rx_empty;
  assign tx_push  = i_tx_push && !tx_full;
  assign status   = {rx_full, rx_empty, tx_full, tx_empty, ovr, unr, 2'b00};

  always_comb begin
    state_d  = state;
    mode     = state;
    load     = 1'b0;
    load_val = 8'h00;
    rx_push  = 1'b0;
    tx_pop   = 1'b0;
    ov_set   = 1'b0;
    un_set   = 1'b0;
    if (state == CMD) begin
      unique case (byte_in)
        8'h02:   mode = WRITE;
        8'h03:   mode = READ;
        8'h05:   mode = STATUS;
`ifdef SPI_MBOX_ECHO_EN
        8'h0B:   mode = ECHO;
`endif
        default: mode = IGNORE;
      endcase
    end
    if (cs_s) begin
      state_d = IDLE;
    end else if (state == IDLE) begin
      if (cs_fall) state_d = CMD;
    end else if (boundary) begin
      state_d = mode;
      load    = 1'b1;
      unique case (mode)
        WRITE: begin
          if (state == WRITE) begin
            if (rx_full) ov_set = 1'b1;
            else         rx_push = 1'b1;
          end
        end
        READ: begin
          if (tx_empty) begin
            load_val = 8'hFF;
            un_set   = 1'b1;
          end else begin
            load_val = tx_mem[tx_rp];
            tx_pop   = 1'b1;
          end
        end
        STATUS: load_val = status;
        ECHO:   if (state == ECHO) load_val = byte_in;
        default: load_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shin    <= '0;
      sr      <= '0;
      fresh   <= 1'b0;
      miso    <= 1'b0;
      ovr     <= 1'b0;
      unr     <= 1'b0;
    end else begin
      state <= state_d;
      ovr   <= ov_set | (ovr & ~i_clr_flags);
      unr   <= un_set | (unr & ~i_clr_flags);
      if (cs_s || state == IDLE) begin
        bit_cnt <= '0;
        shin    <= '0;
        sr      <= '0;
        fresh   <= 1'b0;
        miso    <= 1'b0;
      end else begin
        if (rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          shin    <= byte_in;
        end
        // First fall after a load presents bit 7 without shifting.
        if (load) begin
          sr    <= load_val;
          fresh <= 1'b1;
        end else if (fall) begin
          if (fresh) begin
            miso  <= sr[7];
            fresh <= 1'b0;
          end else begin
            miso <= sr[6];
            sr   <= {sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= 8'h00;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= byte_in;
        rx_wp         <= rx_wp + AW'(1);
      end
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= i_tx_data;
  end

  assign o_FT_MISO  = miso;
  assign o_rx_data  = rx_mem[rx_rp];
  assign o_rx_empty = rx_empty;
  assign o_tx_full  = tx_full;
  assign o_irq      = ~rx_empty;

endmodule
